// File: rtl/csr_pkg.sv
// csr_pkg: shared constants for the machine-mode CSR unit.
//   - CSR address map, CSR op encodings, mstatus/mip/mie bit positions
//   - default misa value plus a helper that adjusts MXL for the data width
package csr_pkg;

  // CSR addresses
  localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
  localparam logic [11:0] CSR_MARCHID       = 12'hF12;
  localparam logic [11:0] CSR_MIMPID        = 12'hF13;
  localparam logic [11:0] CSR_MHARTID       = 12'hF14;
  localparam logic [11:0] CSR_MSTATUS       = 12'h300;
  localparam logic [11:0] CSR_MISA          = 12'h301;
  localparam logic [11:0] CSR_MIE           = 12'h304;
  localparam logic [11:0] CSR_MTVEC         = 12'h305;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
  localparam logic [11:0] CSR_MEPC          = 12'h341;
  localparam logic [11:0] CSR_MCAUSE        = 12'h342;
  localparam logic [11:0] CSR_MTVAL         = 12'h343;
  localparam logic [11:0] CSR_MIP           = 12'h344;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_CYCLE         = 12'hC00;
  localparam logic [11:0] CSR_INSTRET       = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH      = 12'hC82;

  // CSR operation encodings
  typedef enum logic [1:0] {
    OpRead = 2'b00,
    OpRw   = 2'b01,
    OpRs   = 2'b10,
    OpRc   = 2'b11
  } csr_op_e;

  // mstatus bit positions
  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;
  localparam int unsigned MSTATUS_MPP_LO   = 11;
  localparam int unsigned MSTATUS_MPP_HI   = 12;

  // mip / mie bit positions
  localparam int unsigned MIP_MSIP_BIT = 3;
  localparam int unsigned MIP_MTIP_BIT = 7;
  localparam int unsigned MIP_MEIP_BIT = 11;
  localparam logic [11:0] MIE_WMASK    = 12'h888;

  localparam logic [31:0] MISA_DEFAULT = 32'h4000_0100;

  // MXL lives in the top two bits; it is 1 for RV32 and 2 for RV64.
  function automatic logic [63:0] misa_default(input int unsigned xlen);
    if (xlen == 64) begin
      return {2'b10, 30'd0, 2'b00, MISA_DEFAULT[29:0]};
    end
    return {32'd0, MISA_DEFAULT};
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// csr_counter64: one 64-bit free-running counter with CSR write access.
//   i_clk, i_reset      clock / async active-high reset
//   i_inc               count enable this cycle
//   i_inhibit           freezes the counter
//   i_we_lo, i_we_hi    write lower / upper 32 bits (either beats i_inc)
//   i_wdata_lo/_hi      write data for each half
//   o_value             current 64-bit value (pre-increment for this cycle)
module csr_counter64 (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_inc,
  input  logic        i_inhibit,
  input  logic        i_we_lo,
  input  logic        i_we_hi,
  input  logic [31:0] i_wdata_lo,
  input  logic [31:0] i_wdata_hi,
  output logic [63:0] o_value
);

  logic [63:0] r_value;
  logic [63:0] w_value_d;

  always_comb begin
    w_value_d = r_value;
    if (i_we_lo || i_we_hi) begin
      // A write to one half leaves the other half untouched, no increment.
      if (i_we_lo) w_value_d[31:0]  = i_wdata_lo;
      if (i_we_hi) w_value_d[63:32] = i_wdata_hi;
    end else if (i_inc && !i_inhibit) begin
      w_value_d = r_value + 64'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_value <= 64'd0;
    else         r_value <= w_value_d;
  end

  assign o_value = r_value;

endmodule

// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file with CSRRW/RS/RC, privilege and read-only
// checks, mcycle/minstret counters, and trap-entry / mret mstatus updates.
// Optional: define CSR_MCOUNTINHIBIT_EN to implement mcountinhibit (0x320).
// Ports:
//   clk, reset                          clock / async active-high reset
//   csr_req, csr_op, csr_addr, csr_wdata  request (one per cycle max)
//   priv                                current privilege (00 U, 11 M)
//   instr_retire                        bumps minstret
//   trap_valid, trap_cause/pc/tval      trap entry
//   mret                                trap return
//   irq_ext, irq_timer, irq_sw          interrupt levels (reflected in mip)
//   csr_ack, csr_rdata, csr_illegal     registered response, one cycle later
//   mtvec_o, mepc_o                     current mtvec / mepc
//   irq_pending                         mstatus.MIE & |(mip & mie)
module csr_unit
  import csr_pkg::*;
#(
  parameter int unsigned      XLEN     = 32,
  parameter int unsigned      HART_ID  = 0,
  parameter logic [XLEN-1:0]  MISA_VAL = XLEN'(misa_default(XLEN))
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            csr_req,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic [1:0]      priv,
  input  logic            instr_retire,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_tval,
  input  logic            mret,
  input  logic            irq_ext,
  input  logic            irq_timer,
  input  logic            irq_sw,
  output logic            csr_ack,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  output logic [XLEN-1:0] mtvec_o,
  output logic [XLEN-1:0] mepc_o,
  output logic            irq_pending
);

  localparam logic [XLEN-1:0] ALIGN4 = ~XLEN'(3);

  logic            r_mstatus_mie, r_mstatus_mpie;
  logic [XLEN-1:0] r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
  logic            r_ack, r_illegal;
  logic [XLEN-1:0] r_rdata;

  logic [XLEN-1:0] w_mstatus, w_mip, w_old, w_new;
  logic [63:0]     w_mcycle, w_minstret, w_new64;
  logic            w_impl, w_wr_en, w_illegal, w_do_write;
  logic            w_inh_cy, w_inh_ir;
  logic [XLEN-1:0] w_mcountinhibit;

`ifdef CSR_MCOUNTINHIBIT_EN
  logic r_inh_cy, r_inh_ir;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inh_cy <= 1'b0;
      r_inh_ir <= 1'b0;
    end else if (w_do_write && csr_addr == CSR_MCOUNTINHIBIT) begin
      r_inh_cy <= w_new[0];
      r_inh_ir <= w_new[2];
    end
  end
  assign w_inh_cy = r_inh_cy;
  assign w_inh_ir = r_inh_ir;
`else
  assign w_inh_cy = 1'b0;
  assign w_inh_ir = 1'b0;
`endif

  always_comb begin
    w_mcountinhibit    = '0;
    w_mcountinhibit[0] = w_inh_cy;
    w_mcountinhibit[2] = w_inh_ir;

    w_mstatus = '0;
    w_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    w_mstatus[MSTATUS_MPIE_BIT] = r_mstatus_mpie;
    w_mstatus[MSTATUS_MIE_BIT]  = r_mstatus_mie;

    w_mip = '0;
    w_mip[MIP_MSIP_BIT] = irq_sw;
    w_mip[MIP_MTIP_BIT] = irq_timer;
    w_mip[MIP_MEIP_BIT] = irq_ext;
  end

  // Read mux and implemented-address decode.
  always_comb begin
    w_impl = 1'b1;
    w_old  = '0;
    case (csr_addr)
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: w_old = '0;
      CSR_MHARTID:  w_old = XLEN'(HART_ID);
      CSR_MSTATUS:  w_old = w_mstatus;
      CSR_MISA:     w_old = MISA_VAL;
      CSR_MIE:      w_old = r_mie;
      CSR_MTVEC:    w_old = r_mtvec;
      CSR_MSCRATCH: w_old = r_mscratch;
      CSR_MEPC:     w_old = r_mepc;
      CSR_MCAUSE:   w_old = r_mcause;
      CSR_MTVAL:    w_old = r_mtval;
      CSR_MIP:      w_old = w_mip;
`ifdef CSR_MCOUNTINHIBIT_EN
      CSR_MCOUNTINHIBIT: w_old = w_mcountinhibit;
`endif
      CSR_MCYCLE, CSR_CYCLE:     w_old = w_mcycle[XLEN-1:0];
      CSR_MINSTRET, CSR_INSTRET: w_old = w_minstret[XLEN-1:0];
      CSR_MCYCLEH, CSR_CYCLEH: begin
        if (XLEN == 32) w_old = XLEN'(w_mcycle[63:32]);
        else            w_impl = 1'b0;
      end
      CSR_MINSTRETH, CSR_INSTRETH: begin
        if (XLEN == 32) w_old = XLEN'(w_minstret[63:32]);
        else            w_impl = 1'b0;
      end
      default: w_impl = 1'b0;
    endcase
  end

  always_comb begin
    unique case (csr_op)
      OpRw:    w_new = csr_wdata;
      OpRs:    w_new = w_old | csr_wdata;
      OpRc:    w_new = w_old & ~csr_wdata;
      default: w_new = w_old;
    endcase
  end

  // RS/RC with a zero operand is a pure read and may target read-only space.
  assign w_wr_en    = (csr_op == OpRw) || ((csr_op == OpRs || csr_op == OpRc) && |csr_wdata);
  assign w_illegal  = !w_impl || (priv < csr_addr[9:8]) || (w_wr_en && csr_addr[11:10] == 2'b11);
  assign w_do_write = csr_req && w_wr_en && !w_illegal;
  assign w_new64    = 64'(w_new);

  csr_counter64 u_mcycle (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_inc      (1'b1),
    .i_inhibit  (w_inh_cy),
    .i_we_lo    (w_do_write && csr_addr == CSR_MCYCLE),
    .i_we_hi    (w_do_write && (csr_addr == CSR_MCYCLEH || (XLEN == 64 && csr_addr == CSR_MCYCLE))),
    .i_wdata_lo (w_new64[31:0]),
    .i_wdata_hi ((XLEN == 64) ? w_new64[63:32] : w_new64[31:0]),
    .o_value    (w_mcycle)
  );

  csr_counter64 u_minstret (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_inc      (instr_retire),
    .i_inhibit  (w_inh_ir),
    .i_we_lo    (w_do_write && csr_addr == CSR_MINSTRET),
    .i_we_hi    (w_do_write &&
                 (csr_addr == CSR_MINSTRETH || (XLEN == 64 && csr_addr == CSR_MINSTRET))),
    .i_wdata_lo (w_new64[31:0]),
    .i_wdata_hi ((XLEN == 64) ? w_new64[63:32] : w_new64[31:0]),
    .o_value    (w_minstret)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie          <= '0;
      r_mtvec        <= '0;
      r_mscratch     <= '0;
      r_mepc         <= '0;
      r_mcause       <= '0;
      r_mtval        <= '0;
      r_ack          <= 1'b0;
      r_rdata        <= '0;
      r_illegal      <= 1'b0;
    end else begin
      r_ack     <= csr_req;
      r_rdata   <= (csr_req && !w_illegal) ? w_old : '0;
      r_illegal <= csr_req && w_illegal;

      // Trap beats mret, and both beat a same-cycle software write.
      if (trap_valid) begin
        r_mstatus_mpie <= r_mstatus_mie;
        r_mstatus_mie  <= 1'b0;
        r_mepc         <= trap_pc & ALIGN4;
        r_mcause       <= trap_cause;
        r_mtval        <= trap_tval;
      end else if (mret) begin
        r_mstatus_mie  <= r_mstatus_mpie;
        r_mstatus_mpie <= 1'b1;
      end else if (w_do_write) begin
        if (csr_addr == CSR_MSTATUS) begin
          r_mstatus_mie  <= w_new[MSTATUS_MIE_BIT];
          r_mstatus_mpie <= w_new[MSTATUS_MPIE_BIT];
        end
        if (csr_addr == CSR_MEPC)   r_mepc   <= w_new & ALIGN4;
        if (csr_addr == CSR_MCAUSE) r_mcause <= w_new;
        if (csr_addr == CSR_MTVAL)  r_mtval  <= w_new;
      end

      if (w_do_write && csr_addr == CSR_MIE)      r_mie      <= w_new & XLEN'(MIE_WMASK);
      if (w_do_write && csr_addr == CSR_MTVEC)    r_mtvec    <= w_new & ALIGN4;
      if (w_do_write && csr_addr == CSR_MSCRATCH) r_mscratch <= w_new;
    end
  end

  assign csr_ack     = r_ack;
  assign csr_rdata   = r_rdata;
  assign csr_illegal = r_illegal;
  assign mtvec_o     = r_mtvec;
  assign mepc_o      = r_mepc;
  assign irq_pending = r_mstatus_mie && |(w_mip & r_mie);

endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: directed bench for csr_unit (XLEN=32, HART_ID=3).
// Requests push their expected response into a scoreboard queue; a monitor
// pops and compares whenever csr_ack is seen.
module tb_csr_unit;
  import csr_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        csr_req = 1'b0;
  logic [1:0]  csr_op = 2'b00;
  logic [11:0] csr_addr = 12'h000;
  logic [31:0] csr_wdata = 32'h0;
  logic [1:0]  priv = 2'b11;
  logic        instr_retire = 1'b0;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_cause = 32'h0;
  logic [31:0] trap_pc = 32'h0;
  logic [31:0] trap_tval = 32'h0;
  logic        mret = 1'b0;
  logic        irq_ext = 1'b0;
  logic        irq_timer = 1'b0;
  logic        irq_sw = 1'b0;
  logic        csr_ack;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic [31:0] mtvec_o;
  logic [31:0] mepc_o;
  logic        irq_pending;

  int total = 0;
  int bad = 0;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        ill;
    bit          chk_rd;
  } exp_t;

  exp_t sb[$];

  csr_unit #(
    .XLEN    (32),
    .HART_ID (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .csr_req      (csr_req),
    .csr_op       (csr_op),
    .csr_addr     (csr_addr),
    .csr_wdata    (csr_wdata),
    .priv         (priv),
    .instr_retire (instr_retire),
    .trap_valid   (trap_valid),
    .trap_cause   (trap_cause),
    .trap_pc      (trap_pc),
    .trap_tval    (trap_tval),
    .mret         (mret),
    .irq_ext      (irq_ext),
    .irq_timer    (irq_timer),
    .irq_sw       (irq_sw),
    .csr_ack      (csr_ack),
    .csr_rdata    (csr_rdata),
    .csr_illegal  (csr_illegal),
    .mtvec_o      (mtvec_o),
    .mepc_o       (mepc_o),
    .irq_pending  (irq_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Drives one request for exactly one cycle and records its expected response.
  task automatic issue(input string nm, input logic [1:0] op, input logic [11:0] addr,
                       input logic [31:0] wd, input logic [1:0] pv,
                       input logic [31:0] erd, input logic eill, input bit crd);
    exp_t e;
    csr_req   = 1'b1;
    csr_op    = op;
    csr_addr  = addr;
    csr_wdata = wd;
    priv      = pv;
    e.name    = nm;
    e.rdata   = erd;
    e.ill     = eill;
    e.chk_rd  = crd;
    sb.push_back(e);
    @(posedge clk);
    #1;
    csr_req = 1'b0;
    priv    = 2'b11;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (!reset && csr_ack) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ack: got ack=1 expected no response");
      end else begin
        e = sb.pop_front();
        if (e.chk_rd) chk({e.name, "_rdata"}, 64'(csr_rdata), 64'(e.rdata));
        chk({e.name, "_illegal"}, 64'(csr_illegal), 64'(e.ill));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    reset = 1'b0;
    chk("rst_ack", 64'(csr_ack), 64'd0);
    chk("rst_rdata", 64'(csr_rdata), 64'd0);
    chk("rst_illegal", 64'(csr_illegal), 64'd0);
    chk("rst_mepc", 64'(mepc_o), 64'd0);
    chk("rst_mtvec", 64'(mtvec_o), 64'd0);
    chk("rst_irq", 64'(irq_pending), 64'd0);

    issue("hartid", OpRead, 12'hF14, 0, 2'b11, 32'd3, 1'b0, 1);
    issue("mstatus_rst", OpRead, 12'h300, 0, 2'b11, 32'h1800, 1'b0, 1);

    // mscratch RW / RS / RC chain, back to back
    issue("mscr_rw", OpRw, 12'h340, 32'hDEADBEEF, 2'b11, 32'h0, 1'b0, 1);
    issue("mscr_rs", OpRs, 12'h340, 32'h00000010, 2'b11, 32'hDEADBEEF, 1'b0, 1);
    issue("mscr_rc", OpRc, 12'h340, 32'hDEAD0000, 2'b11, 32'hDEADBEFF, 1'b0, 1);
    issue("mscr_rd", OpRead, 12'h340, 0, 2'b11, 32'h0000BEFF, 1'b0, 1);

    // Illegal cases
    issue("upriv_mscr", OpRead, 12'h340, 0, 2'b00, 32'h0, 1'b1, 1);
    issue("wr_ro_f11", OpRw, 12'hF11, 32'h1, 2'b11, 32'h0, 1'b1, 1);
    issue("unimpl_7c0", OpRead, 12'h7C0, 0, 2'b11, 32'h0, 1'b1, 1);
    issue("mscr_kept", OpRead, 12'h340, 0, 2'b11, 32'h0000BEFF, 1'b0, 1);

    // mcycle carry into mcycleh; old low half unknown so not compared
    issue("mcych_wr", OpRw, 12'hB80, 32'h0, 2'b11, 32'h0, 1'b0, 1);
    issue("mcyc_wr", OpRw, 12'hB00, 32'hFFFFFFFF, 2'b11, 32'h0, 1'b0, 0);
    issue("cycle_rs0", OpRs, 12'hC00, 32'h0, 2'b11, 32'hFFFFFFFF, 1'b0, 1);
    issue("mcych_rd", OpRead, 12'hB80, 0, 2'b11, 32'h1, 1'b0, 1);
    issue("mcyc_wrap", OpRead, 12'hB00, 0, 2'b11, 32'h1, 1'b0, 1);
    issue("cycleh_rd", OpRead, 12'hC80, 0, 2'b11, 32'h1, 1'b0, 1);

    // minstret: write beats same-cycle retire, then counts retires
    instr_retire = 1'b1;
    issue("minst_wr", OpRw, 12'hB02, 32'd5, 2'b11, 32'h0, 1'b0, 1);
    idle(2);
    instr_retire = 1'b0;
    issue("minst_rd", OpRead, 12'hB02, 0, 2'b11, 32'd7, 1'b0, 1);
    issue("minsth_rd", OpRead, 12'hB82, 0, 2'b11, 32'd0, 1'b0, 1);

`ifdef CSR_MCOUNTINHIBIT_EN
    issue("inh_wr", OpRw, 12'h320, 32'h1, 2'b11, 32'h0, 1'b0, 1);
    issue("mcyc_set", OpRw, 12'hB00, 32'h100, 2'b11, 32'h0, 1'b0, 0);
    idle(3);
    issue("mcyc_hold", OpRead, 12'hB00, 0, 2'b11, 32'h100, 1'b0, 1);
    issue("inh_rd", OpRw, 12'h320, 32'hFF, 2'b11, 32'h1, 1'b0, 1);
    issue("inh_mask", OpRw, 12'h320, 32'h0, 2'b11, 32'h5, 1'b0, 1);
`else
    issue("inh_unimpl", OpRead, 12'h320, 0, 2'b11, 32'h0, 1'b1, 1);
`endif

    // misa / mip / mtvec
    issue("misa_rd", OpRead, 12'h301, 0, 2'b11, 32'h40000100, 1'b0, 1);
    issue("misa_wr", OpRw, 12'h301, 32'h0, 2'b11, 32'h40000100, 1'b0, 1);
    issue("misa_kept", OpRead, 12'h301, 0, 2'b11, 32'h40000100, 1'b0, 1);
    irq_ext = 1'b1;
    irq_sw  = 1'b1;
    issue("mip_wr", OpRw, 12'h344, 32'h0, 2'b11, 32'h808, 1'b0, 1);
    irq_sw  = 1'b0;
    irq_ext = 1'b0;
    issue("mtvec_wr", OpRw, 12'h305, 32'h2003, 2'b11, 32'h0, 1'b0, 1);
    chk("mtvec_o", 64'(mtvec_o), 64'h2000);

    // Trap entry with a colliding mepc write, then mret
    issue("mie_set", OpRw, 12'h300, 32'h8, 2'b11, 32'h1800, 1'b0, 1);
    issue("mstatus_mie", OpRead, 12'h300, 0, 2'b11, 32'h1808, 1'b0, 1);
    trap_valid = 1'b1;
    trap_cause = 32'd11;
    trap_pc    = 32'h1006;
    trap_tval  = 32'h55;
    issue("trap_mepc_wr", OpRw, 12'h341, 32'hAAAA, 2'b11, 32'h0, 1'b0, 1);
    trap_valid = 1'b0;
    chk("mepc_o", 64'(mepc_o), 64'h1004);
    issue("mepc_rd", OpRead, 12'h341, 0, 2'b11, 32'h1004, 1'b0, 1);
    issue("mcause_rd", OpRead, 12'h342, 0, 2'b11, 32'd11, 1'b0, 1);
    issue("mtval_rd", OpRead, 12'h343, 0, 2'b11, 32'h55, 1'b0, 1);
    issue("mstatus_trap", OpRead, 12'h300, 0, 2'b11, 32'h1880, 1'b0, 1);
    mret = 1'b1;
    idle(1);
    mret = 1'b0;
    issue("mstatus_mret", OpRead, 12'h300, 0, 2'b11, 32'h1888, 1'b0, 1);

    // Interrupt pending
    issue("mie_wr", OpRw, 12'h304, 32'hFFFF_FFFF, 2'b11, 32'h0, 1'b0, 1);
    issue("mie_rd", OpRw, 12'h304, 32'h800, 2'b11, 32'h888, 1'b0, 1);
    chk("irq_idle", 64'(irq_pending), 64'd0);
    irq_timer = 1'b1;
    #1;
    chk("irq_timer_masked", 64'(irq_pending), 64'd0);
    irq_ext = 1'b1;
    #1;
    chk("irq_ext", 64'(irq_pending), 64'd1);
    irq_ext   = 1'b0;
    irq_timer = 1'b0;

    // Reset in the middle of a request discards its response
    idle(2);
    csr_req  = 1'b1;
    csr_op   = OpRead;
    csr_addr = 12'hF14;
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
    csr_req = 1'b0;
    chk("rst_mid_ack", 64'(csr_ack), 64'd0);
    reset = 1'b0;
    idle(1);
    chk("rst_post_ack", 64'(csr_ack), 64'd0);
    chk("rst_mepc2", 64'(mepc_o), 64'd0);
    issue("mstatus_rst2", OpRead, 12'h300, 0, 2'b11, 32'h1800, 1'b0, 1);
    issue("mscr_rst2", OpRead, 12'h340, 0, 2'b11, 32'h0, 1'b0, 1);

    idle(3);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
